// File: rtl/full_sub_data.sv
// full_sub_data: registered WIDTH-bit full subtractor.
//   d = (a - b - bin) mod 2^WIDTH, with borrow-out, zero and signed-overflow flags.
//   Results are captured behind a valid qualifier.
//   A stage whose valid is low holds its previous result.
// Optional build macro FULL_SUB_DATA_PIPE2_EN:
//   adds a second register stage, so latency becomes 2 cycles.
//   Throughput stays at one result per cycle.
module full_sub_data #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    input  logic             in_valid_i,
    output logic [WIDTH-1:0] d_o,
    output logic             bout_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             out_valid_o
);

    // Sign-extended difference: the low WIDTH bits are the modular result.
    // The top two bits disagree exactly when the signed result leaves the WIDTH-bit range.
    logic [WIDTH:0]   sdiff;
    logic [WIDTH:0]   b_plus_bin;
    logic [WIDTH-1:0] d_d;
    logic             bout_d;
    logic             zero_d;
    logic             ovf_d;

    // Combinational subtract and flag generation for the value about to be captured
    always_comb begin
        sdiff      = {a_i[WIDTH-1], a_i} - {b_i[WIDTH-1], b_i} - {{WIDTH{1'b0}}, bin_i};
        b_plus_bin = {1'b0, b_i} + {{WIDTH{1'b0}}, bin_i};
        d_d        = sdiff[WIDTH-1:0];
        bout_d     = ({1'b0, a_i} < b_plus_bin);
        zero_d     = (sdiff[WIDTH-1:0] == '0);
        ovf_d      = sdiff[WIDTH] ^ sdiff[WIDTH-1];
    end

    logic [WIDTH-1:0] d1_q;
    logic             bout1_q;
    logic             zero1_q;
    logic             ovf1_q;
    logic             v1_q;

    // First stage: capture on in_valid, otherwise hold data and drop valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_q    <= '0;
            bout1_q <= 1'b0;
            zero1_q <= 1'b0;
            ovf1_q  <= 1'b0;
            v1_q    <= 1'b0;
        end else begin
            v1_q <= in_valid_i;
            if (in_valid_i) begin
                d1_q    <= d_d;
                bout1_q <= bout_d;
                zero1_q <= zero_d;
                ovf1_q  <= ovf_d;
            end
        end
    end

`ifdef FULL_SUB_DATA_PIPE2_EN
    logic [WIDTH-1:0] d2_q;
    logic             bout2_q;
    logic             zero2_q;
    logic             ovf2_q;
    logic             v2_q;

    // Second stage: same hold-on-invalid behaviour, fed by the first stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d2_q    <= '0;
            bout2_q <= 1'b0;
            zero2_q <= 1'b0;
            ovf2_q  <= 1'b0;
            v2_q    <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                d2_q    <= d1_q;
                bout2_q <= bout1_q;
                zero2_q <= zero1_q;
                ovf2_q  <= ovf1_q;
            end
        end
    end

    assign d_o         = d2_q;
    assign bout_o      = bout2_q;
    assign zero_o      = zero2_q;
    assign ovf_o       = ovf2_q;
    assign out_valid_o = v2_q;
`else
    assign d_o         = d1_q;
    assign bout_o      = bout1_q;
    assign zero_o      = zero1_q;
    assign ovf_o       = ovf1_q;
    assign out_valid_o = v1_q;
`endif

endmodule

// File: tb/tb_full_sub_data.sv
// Self-checking bench for full_sub_data (WIDTH = 1, 4 and 8 instances).
module tb_full_sub_data;

`ifdef FULL_SUB_DATA_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // WIDTH=1 instance
    logic       a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0, v1 = 1'b0;
    logic       d1, bout1, zero1, ovf1, ov1;
    // WIDTH=4 instance
    logic [3:0] a4 = '0, b4 = '0;
    logic       bin4 = 1'b0, v4 = 1'b0;
    logic [3:0] d4;
    logic       bout4, zero4, ovf4, ov4;
    // WIDTH=8 instance
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0, v8 = 1'b0;
    logic [7:0] d8;
    logic       bout8, zero8, ovf8, ov8;

    full_sub_data #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .a_i(a1), .b_i(b1), .bin_i(bin1), .in_valid_i(v1),
        .d_o(d1), .bout_o(bout1), .zero_o(zero1), .ovf_o(ovf1), .out_valid_o(ov1));
    full_sub_data #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .a_i(a4), .b_i(b4), .bin_i(bin4), .in_valid_i(v4),
        .d_o(d4), .bout_o(bout4), .zero_o(zero4), .ovf_o(ovf4), .out_valid_o(ov4));
    full_sub_data #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .a_i(a8), .b_i(b8), .bin_i(bin8), .in_valid_i(v8),
        .d_o(d8), .bout_o(bout8), .zero_o(zero8), .ovf_o(ovf8), .out_valid_o(ov8));

    // Reference: exact integer arithmetic, unsigned and two's-complement views
    function automatic void ref_sub(input int w, input longint a, input longint b,
                                    input longint bin, output longint d, output bit bout,
                                    output bit zero, output bit ovf);
        longint m, half, ex, sa, sb, sex;
        m    = longint'(1) << w;
        half = longint'(1) << (w - 1);
        ex   = a - b - bin;
        d    = ((ex % m) + m) % m;
        bout = (a < b + bin);
        zero = (d == 0);
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        sex  = sa - sb - bin;
        ovf  = (sex < -half) || (sex > half - 1);
    endfunction

    task automatic test_reset();
        #3;
        n_vec++;
        if ({d8, bout8, zero8, ovf8, ov8} !== 12'h0) begin
            n_bad++;
            $display("FAIL reset_w8: got d=%h bout=%b zero=%b ovf=%b ov=%b, want all 0",
                     d8, bout8, zero8, ovf8, ov8);
        end
        n_vec++;
        if ({ov1, ov4, d1, d4} !== 7'h0) begin
            n_bad++;
            $display("FAIL reset_w1_w4: got ov1=%b ov4=%b d1=%b d4=%h, want 0", ov1, ov4, d1, d4);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_truth_w1();
        bit exp_d [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
        bit exp_b [8] = '{0, 1, 1, 1, 0, 0, 0, 1};
        for (int t = 0; t < 8 + LAT; t++) begin
            @(negedge clk);
            if (t >= LAT) begin
                n_vec++;
                if ({ov1, d1, bout1} !== {1'b1, exp_d[t-LAT], exp_b[t-LAT]}) begin
                    n_bad++;
                    $display("FAIL truth_w1 abc=%0d: got ov=%b d=%b bout=%b, want ov=1 d=%b bout=%b",
                             t - LAT, ov1, d1, bout1, exp_d[t-LAT], exp_b[t-LAT]);
                end
            end
            if (t < 8) begin
                {a1, b1, bin1} = 3'(t);
                v1 = 1'b1;
            end else begin
                v1 = 1'b0;
            end
        end
        @(negedge clk);
        n_vec++;
        if (ov1 !== 1'b0) begin
            n_bad++;
            $display("FAIL truth_w1_valid_drop: got ov=%b, want 0", ov1);
        end
    endtask

    // Present one W8 vector for a single cycle and advance to the cycle its result is visible
    task automatic pulse8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; v8 = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) begin
                v8 = 1'b0;
                a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            end
        end
    endtask

    task automatic test_borrow_chain();
        pulse8(8'h00, 8'hFF, 1'b1);
        n_vec++;
        if ({ov8, d8, bout8, zero8, ovf8} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL borrow_00_ff: got ov=%b d=%h bout=%b zero=%b ovf=%b, want 1 00 1 1 0",
                     ov8, d8, bout8, zero8, ovf8);
        end
        pulse8(8'h80, 8'h01, 1'b0);
        n_vec++;
        if ({ov8, d8, bout8, zero8, ovf8} !== {1'b1, 8'h7F, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL ovf_80_01: got ov=%b d=%h bout=%b zero=%b ovf=%b, want 1 7f 0 0 1",
                     ov8, d8, bout8, zero8, ovf8);
        end
        pulse8(8'h5A, 8'h5A, 1'b0);
        n_vec++;
        if ({ov8, d8, bout8, zero8, ovf8} !== {1'b1, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL equal_ops: got ov=%b d=%h bout=%b zero=%b ovf=%b, want 1 00 0 1 0",
                     ov8, d8, bout8, zero8, ovf8);
        end
    endtask

    task automatic test_hold();
        pulse8(8'h10, 8'h03, 1'b0);
        n_vec++;
        if ({ov8, d8, bout8} !== {1'b1, 8'h0D, 1'b0}) begin
            n_bad++;
            $display("FAIL hold_load: got ov=%b d=%h bout=%b, want 1 0d 0", ov8, d8, bout8);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            n_vec++;
            if ({ov8, d8, bout8, zero8} !== {1'b0, 8'h0D, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: got ov=%b d=%h bout=%b zero=%b, want 0 0d 0 0",
                         i, ov8, d8, bout8, zero8);
            end
        end
    endtask

    task automatic test_async_reset();
        pulse8(8'h10, 8'h03, 1'b0);
        n_vec++;
        if ({ov8, d8} !== {1'b1, 8'h0D}) begin
            n_bad++;
            $display("FAIL areset_pre: got ov=%b d=%h, want 1 0d", ov8, d8);
        end
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if ({d8, bout8, zero8, ovf8, ov8} !== 12'h0) begin
            n_bad++;
            $display("FAIL areset_clear: got d=%h bout=%b zero=%b ovf=%b ov=%b, want all 0",
                     d8, bout8, zero8, ovf8, ov8);
        end
        #1 rst = 1'b0;
        pulse8(8'd5, 8'd5, 1'b0);
        n_vec++;
        if ({ov8, d8, zero8, bout8} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL areset_after: got ov=%b d=%h zero=%b bout=%b, want 1 00 1 0",
                     ov8, d8, zero8, bout8);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] qa[$], qb[$];
        logic       qc[$];
        longint     ed;
        bit         eb, ez, eo;
        for (int t = 0; t < 16 + LAT; t++) begin
            @(negedge clk);
            if (t >= LAT) begin
                ref_sub(8, longint'(qa[t-LAT]), longint'(qb[t-LAT]), longint'(qc[t-LAT]),
                        ed, eb, ez, eo);
                n_vec++;
                if ({ov8, d8, bout8, zero8, ovf8} !== {1'b1, 8'(ed), eb, ez, eo}) begin
                    n_bad++;
                    $display("FAIL b2b_%0d a=%h b=%h bin=%b: got ov=%b d=%h bout=%b zero=%b ovf=%b, want 1 %h %b %b %b",
                             t - LAT, qa[t-LAT], qb[t-LAT], qc[t-LAT], ov8, d8, bout8, zero8, ovf8,
                             8'(ed), eb, ez, eo);
                end
            end
            if (t < 16) begin
                a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); v8 = 1'b1;
                qa.push_back(a8); qb.push_back(b8); qc.push_back(bin8);
            end else begin
                v8 = 1'b0;
            end
        end
        @(negedge clk);
        n_vec++;
        if (ov8 !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end_valid: got ov=%b, want 0", ov8);
        end
    endtask

    task automatic test_random_w4();
        longint ed;
        bit     eb, ez, eo;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom); v4 = 1'b1;
            ref_sub(4, longint'(a4), longint'(b4), longint'(bin4), ed, eb, ez, eo);
            for (int k = 1; k <= LAT; k++) begin
                @(negedge clk);
                if (k == 1) v4 = 1'b0;
            end
            n_vec++;
            if ({ov4, d4, bout4, zero4, ovf4} !== {1'b1, 4'(ed), eb, ez, eo}) begin
                n_bad++;
                $display("FAIL rand_w4 a=%h b=%h bin=%b: got ov=%b d=%h bout=%b zero=%b ovf=%b, want 1 %h %b %b %b",
                         a4, b4, bin4, ov4, d4, bout4, zero4, ovf4, 4'(ed), eb, ez, eo);
            end
        end
    endtask

    task automatic test_pipe_latency();
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd1; bin4 = 1'b1; v4 = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            v4 = 1'b0;
            n_vec++;
            if (ov4 !== (k == LAT)) begin
                n_bad++;
                $display("FAIL pipe_valid_k%0d: got ov=%b, want %b", k, ov4, (k == LAT));
            end
            if (k == LAT) begin
                n_vec++;
                if ({d4, bout4} !== {4'd1, 1'b0}) begin
                    n_bad++;
                    $display("FAIL pipe_data: got d=%h bout=%b, want 1 0", d4, bout4);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_truth_w1();
        test_borrow_chain();
        test_hold();
        test_async_reset();
        test_back_to_back();
        test_random_w4();
        test_pipe_latency();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/full_sub_data.md
Name: full_sub_data

Overview:
- Registered full subtractor: computes d = a − b − bin and borrow-out bout for WIDTH-bit unsigned operands.
- Outputs are captured on the clock behind a valid qualifier.
- Datapath primitive for ALU and borrow-chain logic; WIDTH=1 gives the classic 1-bit full subtractor.

Parameters:
- WIDTH, 1, operand and difference width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- a  input  WIDTH  minuend (unsigned)
- b  input  WIDTH  subtrahend (unsigned)
- bin  input  1  borrow-in
- in_valid  input  1  operands valid this cycle
- d  output  WIDTH  registered difference
- bout  output  1  registered borrow-out
- zero  output  1  registered flag, d == 0
- ovf  output  1  registered signed-overflow flag
- out_valid  output  1  d/bout/zero/ovf hold a new result

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset: while rst=1, d=0, bout=0, zero=0, ovf=0, out_valid=0 immediately, independent of clk. First capture occurs on the first rising clk edge after rst deasserts.
- Arithmetic, WIDTH+1-bit: diff = {1'b0,a} − {1'b0,b} − bin.
  - d = diff[WIDTH−1:0], i.e. the result modulo 2^WIDTH.
  - bout = 1 iff a < b + bin (unsigned compare, no truncation of b + bin).
- WIDTH=1 equivalences:
  - d = a ^ b ^ bin.
  - bout = (~a & b) | (~a & bin) | (b & bin).
- zero = (d == 0), evaluated on the value being registered.
- ovf: a and b are interpreted as two's-complement WIDTH-bit values. ovf=1 iff the exact result a − b − bin lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Latency: 1 cycle. When in_valid=1 at rising edge N, the results for those operands appear after edge N and out_valid=1 for exactly that cycle.
- in_valid=0 at an edge:
  - out_valid goes to 0.
  - d, bout, zero, ovf hold their previous values.
- Back-to-back: in_valid high on consecutive edges gives one result per cycle; no stalls and no backpressure.
- Boundary cases:
  - a=0, b=2^WIDTH−1, bin=1: d=0, bout=1, zero=1.
  - a=b, bin=0: d=0, bout=0, zero=1.
- Reset mid-stream: any pending or visible result is discarded; out_valid=0 immediately.
- X/unknown inputs while in_valid=0 must not change outputs.

Optional Feature:
- Macro: FULL_SUB_DATA_PIPE2_EN.
- Defined:
  - A second register stage follows the first; latency becomes 2 cycles.
  - out_valid is delayed identically and stays aligned with its data.
  - Hold semantics apply per stage: a stage whose valid is 0 keeps its data.
  - rst clears both stages asynchronously.
  - Throughput remains one result per cycle.
- Not defined: single stage, latency 1, as described above.

Test Plan:
- WIDTH=1, truth table: sweep {a,b,bin}=000..111, one per cycle with in_valid=1. Required (d,bout) one cycle later: 000→(0,0), 001→(1,1), 010→(1,1), 011→(0,1), 100→(1,0), 101→(0,0), 110→(0,0), 111→(1,1).
- WIDTH=8, borrow chain:
  - a=0x00, b=0xFF, bin=1 → d=0x00, bout=1, zero=1, ovf=0.
  - a=0x80, b=0x01, bin=0 → d=0x7F, bout=0, ovf=1.
- Hold: result a=0x10, b=0x03, bin=0 (d=0x0D), then in_valid=0 for 3 cycles with random a/b/bin → d stays 0x0D, bout=0, out_valid=0 on those cycles.
- Async reset: assert rst between clock edges while out_valid=1, d=0x0D → all outputs 0 immediately. After deassert, a=5, b=5, bin=0 → d=0, zero=1, out_valid=1 one cycle later.
- Back-to-back: 16 consecutive random vectors with in_valid=1 → out_valid high for 16 consecutive cycles; each d/bout matches the reference model at latency 1 (latency 2 with FULL_SUB_DATA_PIPE2_EN).
- Pipe feature: with FULL_SUB_DATA_PIPE2_EN, a single in_valid pulse with a=3, b=1, bin=1 (WIDTH=4) → out_valid pulses exactly 2 cycles later with d=1, bout=0.
